// File: rtl/approx_pkg.sv
// Shared definitions for the approximation controllers: FSM encodings,
// ALU mode codes and fixed-point constant helpers.
package approx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Series-controller ALU modes, kept here so both controllers agree on them.
  typedef enum logic [2:0] {
    ALU_IDLE = 3'd0,
    ADD_ONE  = 3'd1,
    SUB_ONE  = 3'd2,
    ADD_SUB  = 3'd3,
    MULTIPLY = 3'd4
  } alu_mode_e;

  // 0.5 in the fixed-point format
  function automatic longint unsigned half_of(input int frac_w);
    return 64'd1 << (frac_w - 1);
  endfunction

  // 2.0 in the fixed-point format
  function automatic longint unsigned two_of(input int frac_w);
    return 64'd2 << frac_w;
  endfunction

  // Narrowest signed width holding -frac_w .. +(data_w - frac_w)
  function automatic int exp_w_min(input int data_w, input int frac_w);
    int w;
    w = 1;
    while (((1 << (w - 1)) < frac_w) || (((1 << (w - 1)) - 1) < (data_w - frac_w)))
      w++;
    return w;
  endfunction

endpackage

// File: rtl/norm_step.sv
// One normalization step: classifies x against [0.5, 2.0) and produces the
// single-bit shifted candidate in the direction that moves x toward range.
module norm_step
  import approx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic [DATA_W-1:0] x,
  output logic              in_range,
  output logic              is_zero,
  output logic              dir,
  output logic [DATA_W-1:0] x_next
);

  localparam logic [DATA_W-1:0] HALF = DATA_W'(half_of(FRAC_W));
  localparam logic [DATA_W-1:0] TWO  = DATA_W'(two_of(FRAC_W));

  // dir=1 means shift right (x too large), dir=0 means shift left.
  assign is_zero  = (x == '0);
  assign dir      = (x >= TWO);
  assign in_range = (x >= HALF) && !dir;
  assign x_next   = dir ? (x >> 1) : (x << 1);

endmodule

// File: rtl/range_scaler_ctrl.sv
// Range-reduction sequencer: shifts x one bit per cycle into [0.5, 2.0) and
// tracks the exponent k so that x_in = x_norm * 2^k.
module range_scaler_ctrl
  import approx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int EXP_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] x_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] x_o,
  output logic [EXP_W-1:0]  k_o
);

  if (EXP_W < exp_w_min(DATA_W, FRAC_W)) begin : g_exp_w_check
    $error("range_scaler_ctrl: EXP_W too narrow for exponent range");
  end

  state_e                   state, state_nx;
  logic [DATA_W-1:0]        x_r;
  logic signed [EXP_W-1:0]  k_r;
  logic signed [EXP_W-1:0]  k_step;
  logic                     err_r;
  logic                     in_range, is_zero, dir;
  logic [DATA_W-1:0]        x_next;
  logic                     kill;

  norm_step #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_norm_step (
    .x        (x_r),
    .in_range (in_range),
    .is_zero  (is_zero),
    .dir      (dir),
    .x_next   (x_next)
  );

  // Abort only matters outside IDLE; in IDLE a simultaneous start wins.
  assign kill   = abort_i && (state != ST_IDLE);
  assign busy_o = (state != ST_IDLE);
  assign k_step = dir ? EXP_W'(1) : '1;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start_i) state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_NORM;
      ST_NORM: if (is_zero || in_range) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (kill) state_nx = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      x_r    <= '0;
      k_r    <= '0;
      err_r  <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      x_o    <= '0;
      k_o    <= '0;
    end else begin
      state  <= state_nx;
      done_o <= 1'b0;
      if (!kill) begin
        unique case (state)
          ST_IDLE: begin
            if (start_i) begin
              x_r   <= x_i;
              k_r   <= '0;
              err_r <= 1'b0;
              err_o <= 1'b0;
            end
          end
          ST_NORM: begin
            if (is_zero) begin
              err_r <= 1'b1;
              x_r   <= '0;
              k_r   <= '0;
            end else if (!in_range) begin
              x_r <= x_next;
              k_r <= k_r + k_step;
            end
          end
          ST_DONE: begin
            done_o <= 1'b1;
            x_o    <= x_r;
            k_o    <= k_r;
            err_o  <= err_r;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_range_scaler_ctrl.sv
// Directed bench for range_scaler_ctrl: normalization results, latency,
// error case, ignored start, abort and asynchronous reset.
module tb_range_scaler_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        abort_i;
  logic [31:0] x_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] x_o;
  logic [5:0]  k_o;

  int n_tests = 0;
  int n_fail  = 0;

  range_scaler_ctrl #(
    .DATA_W (32),
    .FRAC_W (16),
    .EXP_W  (6)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .abort_i (abort_i),
    .x_i     (x_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .x_o     (x_o),
    .k_o     (k_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Start a request at edge t0, then watch 40 cycles. Optional extra start and
  // abort pulses are sampled at edge t<extra_start>/t<abort_at> (0 = none).
  task automatic run(input string name, input logic [31:0] x, input int extra_start,
                     input int abort_at, input int exp_dones, input int exp_lat,
                     input logic [31:0] exp_x, input logic [5:0] exp_k, input logic exp_err);
    int dones;
    int lat;
    dones = 0;
    lat   = 0;
    @(negedge clk);
    x_i     = x;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    x_i     = 32'hDEAD_BEEF;
    for (int c = 1; c <= 40; c++) begin
      start_i = (c == extra_start);
      abort_i = (c == abort_at);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      abort_i = 1'b0;
      if (c == 1) check({name, "/busy_t1"}, 32'(busy_o), 32'd1);
      if (done_o) begin
        dones++;
        if (lat == 0) lat = c;
      end
    end
    check({name, "/dones"}, 32'(dones), 32'(exp_dones));
    if (exp_dones == 1) check({name, "/latency"}, 32'(lat), 32'(exp_lat));
    check({name, "/x_o"}, x_o, exp_x);
    check({name, "/k_o"}, 32'(k_o), 32'(exp_k));
    check({name, "/err_o"}, 32'(err_o), 32'(exp_err));
    check({name, "/busy_end"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    x_i     = '0;
    #12;
    check("rst/busy", 32'(busy_o), 32'd0);
    check("rst/done", 32'(done_o), 32'd0);
    check("rst/err",  32'(err_o),  32'd0);
    check("rst/x_o",  x_o,         32'd0);
    check("rst/k_o",  32'(k_o),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("one",     32'h0001_0000, 0, 0, 1,  3, 32'h0001_0000, 6'h00, 1'b0);
    run("eight",   32'h0008_0000, 0, 0, 1,  6, 32'h0001_0000, 6'h03, 1'b0);
    run("quarter", 32'h0000_4000, 0, 0, 1,  4, 32'h0000_8000, 6'h3F, 1'b0);
    run("lsb",     32'h0000_0001, 0, 0, 1, 18, 32'h0000_8000, 6'h31, 1'b0);
    run("allones", 32'hFFFF_FFFF, 0, 0, 1, 18, 32'h0001_FFFF, 6'h0F, 1'b0);
    run("zero",    32'h0000_0000, 0, 0, 1,  3, 32'h0000_0000, 6'h00, 1'b1);
    run("ign_st",  32'h0001_0000, 2, 0, 1,  3, 32'h0001_0000, 6'h00, 1'b0);

    // Establish known outputs, then abort an 8.0 run mid-normalization.
    run("pre_ab",  32'h0000_4000, 0, 0, 1,  4, 32'h0000_8000, 6'h3F, 1'b0);
    run("abort",   32'h0008_0000, 2, 5, 0,  0, 32'h0000_8000, 6'h3F, 1'b0);

    // Asynchronous reset in the middle of the cycle before t3 of an 8.0 run.
    @(negedge clk);
    x_i     = 32'h0008_0000;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst/busy", 32'(busy_o), 32'd0);
    check("arst/done", 32'(done_o), 32'd0);
    check("arst/x_o",  x_o,         32'd0);
    check("arst/k_o",  32'(k_o),    32'd0);
    check("arst/err",  32'(err_o),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 32'h0001_0000, 0, 0, 1, 3, 32'h0001_0000, 6'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
